// File: rtl/div_iter_if.sv
// ============================================================================
// Module  : div_iter_if
// Purpose : ALU <-> divider handshake. The ALU is the master and the divider
//           is the slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_iter_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module  : div_iter
// Purpose : Multi-cycle radix-2 restoring divider (DIV/DIVU) that returns
//           {remainder, quotient}. DIV_EARLY_OUT_EN skips the iterations
//           when |divisor| > |dividend|.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [1:0] C_FREE   = 2'd0;
  localparam logic [1:0] C_BYZERO = 2'd1;
  localparam logic [1:0] C_ON     = 2'd2;
  localparam logic [1:0] C_END    = 2'd3;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                w_sign1, w_sign2, w_early, w_qbit;
  logic [DATA_W-1:0]   w_mag1, w_mag2, w_quo, w_rem, w_quo_fix, w_rem_fix;
  logic [DATA_W:0]     w_trial, w_diff;

  assign w_sign1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign w_sign2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign w_mag1  = w_sign1 ? -bus.opdata1_i : bus.opdata1_i;
  assign w_mag2  = w_sign2 ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_mag2 > w_mag1);
`else
  assign w_early = 1'b0;
`endif

  // dvd_q shifts left each step; its vacated LSBs collect the quotient bits.
  assign w_trial   = {rem_q, dvd_q[DATA_W-1]};
  assign w_diff    = w_trial - {1'b0, dvs_q};
  assign w_qbit    = ~w_diff[DATA_W];
  assign w_rem     = w_qbit ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quo     = {dvd_q[DATA_W-2:0], w_qbit};
  assign w_quo_fix = negq_q ? -w_quo : w_quo;
  assign w_rem_fix = negr_q ? -w_rem : w_rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      C_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          dvd_d  = w_mag1;
          dvs_d  = w_mag2;
          rem_d  = '0;
          cnt_d  = '0;
          negq_d = w_sign1 ^ w_sign2;
          negr_d = w_sign1;
          if (bus.opdata2_i == '0) begin
            state_d = C_BYZERO;
          end else if (w_early) begin
            state_d  = C_END;
            ready_d  = 1'b1;
            result_d = {bus.opdata1_i, {DATA_W{1'b0}}};
          end else begin
            state_d = C_ON;
          end
        end
      end
      C_BYZERO: begin
        if (bus.annul_i) begin
          state_d = C_FREE;
        end else begin
          state_d  = C_END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
      C_ON: begin
        if (bus.annul_i) begin
          state_d  = C_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          dvd_d = w_quo;
          rem_d = w_rem;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_d  = C_END;
            ready_d  = 1'b1;
            result_d = {w_rem_fix, w_quo_fix};
          end
        end
      end
      C_END: begin
        if (!bus.start_i) begin
          state_d  = C_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = C_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= C_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
// Module  : tb_div_iter
// Purpose : Self-checking bench for div_iter (directed + random operations).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_iter;

  localparam int DATA_W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div_iter_if #(.DATA_W(DATA_W)) bus ();

  div_iter #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, truncating division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn);
    logic [31:0] ma, mb;
    if (b == 32'd0) return 2;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (EARLY_EN && (mb > ma)) return 1;
    return DATA_W + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input string tag);
    int n;
    int lat;
    lat = ref_lat(a, b, sgn);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sgn;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sgn;
    n = 1;
    while (bus.ready_o !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " result"}, bus.result_o, exp);
    @(posedge clk); #1;
    check({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, " hold result"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, " drop result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    bit          seen;
    checks   = 0;
    failures = 0;
    rst              = 1'b0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    #1;
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "u100/7");
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "s-7/2");
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "s7/-2");
    run_op(32'h1234, 32'd0, 1'b0, 64'd0, "u/0");
    run_op(32'h1234, 32'd0, 1'b1, 64'd0, "s/0");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "smin/-1");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, "umax/umax");
    run_op(32'd5, 32'd9, 1'b0, 64'h00000005_00000000, "u5/9");
    run_op(32'hFFFFFFFB, 32'd9, 1'b1, 64'hFFFFFFFB_00000000, "s-5/9");

    // Annul mid-iteration: no result may ever appear.
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0) seen = 1'b1;
    end
    check("annul no ready", 64'(seen), 64'd0);
    check("annul result", bus.result_o, 64'd0);
    run_op(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, "u1000/3");

    // start together with annul in FREE is ignored.
    bus.opdata1_i = 32'd77;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0) seen = 1'b1;
    end
    check("start+annul ignored", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of iteration.
    bus.opdata1_i = 32'd100000;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst mid-on ready", 64'(bus.ready_o), 64'd0);
    check("rst mid-on result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0) seen = 1'b1;
    end
    check("rst aborted op", 64'(seen), 64'd0);
    run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, "u9/3");

    // Asynchronous reset while a result is being presented.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("pre-rst end result", bus.result_o, 64'h00000002_0000000E);
    #2 rst = 1'b0;
    #1;
    check("rst in end ready", 64'(bus.ready_o), 64'd0);
    check("rst in end result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = a;
        3: b = 32'hFFFFFFFF;
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(a, b, sgn, ref_div(a, b, sgn), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider.
- Acts as the responder on the ALU divide handshake: it accepts start/signed/operands from the execute-stage ALU and returns a 64-bit {remainder, quotient} for HI/LO with a ready flag.
- Supports signed (DIV) and unsigned (DIVU) division, pipeline annul on flush, and a fast divide-by-zero path.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W; iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div_i  input  1  1 = signed divide, 0 = unsigned; sampled at acceptance.
- opdata1_i  input  DATA_W  dividend; sampled at acceptance.
- opdata2_i  input  DATA_W  divisor; sampled at acceptance.
- start_i  input  1  request; held high by the ALU until ready_o is seen.
- annul_i  input  1  abort the current operation (pipeline flush).
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  output  1  result valid; registered.

Behaviour:
- Reset (rst=0, async): state=FREE, counter=0, result_o=0, ready_o=0, internal operand registers cleared.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0 → latch signed_div_i and operands.
  - Divisor==0 → BYZERO; otherwise → ON with counter=0.
  - In signed mode, latch magnitudes and record neg_q = sign1^sign2 and neg_r = sign1.
  - start_i with annul_i=1 is ignored.
- BYZERO: next edge → END with result 0. annul_i=1 → FREE instead.
- ON:
  - One quotient bit per cycle, MSB first.
  - 33-bit partial remainder: shift in the next dividend bit, trial-subtract the divisor, keep the difference if non-negative, set the quotient bit accordingly.
  - After DATA_W iterations (counter==DATA_W-1), apply sign fix-up: negate the quotient if neg_q, negate the remainder if neg_r (two's complement, DATA_W bits). Load result_o and go to END.
  - annul_i=1 in any ON cycle → FREE, ready_o=0, result_o=0, and no result is delivered.
- END:
  - ready_o=1, result_o held stable.
  - Stay while start_i=1.
  - start_i=0 → FREE on the next edge with ready_o=0 and result_o=0.
  - annul_i is ignored in END.
- Latency, with start sampled in cycle 0:
  - Normal: ready_o high from cycle DATA_W+1 (cycle 33 for DATA_W=32).
  - Divide by zero: ready_o high from cycle 2.
- Operand changes after acceptance have no effect.
- A new request requires start_i to drop for at least one cycle, since END exits only on start_i=0. Back-to-back requests therefore cost one idle cycle.
- Signed corner case: 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, with no trap or flag.
- Divide by zero returns all-zero HI/LO; no exception.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, if the unsigned magnitude of the divisor exceeds that of the dividend, go directly to END with quotient 0 and remainder = original dividend (sign preserved). ready_o is high from cycle 1, and ON is skipped.
- Undefined: such operands take the full DATA_W+1 cycle path and produce identical numeric results.

Test Plan:
- Unsigned 100/7, start held → ready_o rises exactly at cycle 33; result_o=0x00000002_0000000E; stays stable while start_i=1; result_o=0 and ready_o=0 one cycle after start_i drops.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 → 0x00000001_FFFFFFFD.
- Divide by zero, 0x1234 / 0 → ready_o at cycle 2, result_o=0; same result for signed mode.
- Annul: start 1000/3, assert annul_i for one cycle at cycle 10 → state FREE, ready_o never rises. A fresh 1000/3 request then completes with result_o=0x00000001_0000014D.
- Signed 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000. Unsigned 0xFFFFFFFF / 0xFFFFFFFF → 0x00000000_00000001.
- Async reset asserted mid-ON (cycle 15), independent of clk → ready_o=0 and result_o=0 immediately. After release, 9/3 completes normally with 0x00000000_00000003. With DIV_EARLY_OUT_EN, 5/9 → ready at cycle 1, result 0x00000005_00000000.
